// File: rtl/sbox_word_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sbox_word_arbiter_if                                                  |
// | Two word request/response channels sharing one byte-serial S-box.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface sbox_word_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_word;
   logic        rsp0_valid;
   logic        rsp0_ready;
   logic [31:0] rsp0_word;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_word;
   logic        rsp1_valid;
   logic        rsp1_ready;
   logic [31:0] rsp1_word;

   modport master (
      output req0_valid, req0_word, rsp0_ready,
      output req1_valid, req1_word, rsp1_ready,
      input  req0_ready, rsp0_valid, rsp0_word,
      input  req1_ready, rsp1_valid, rsp1_word
   );

   modport slave (
      input  req0_valid, req0_word, rsp0_ready,
      input  req1_valid, req1_word, rsp1_ready,
      output req0_ready, rsp0_valid, rsp0_word,
      output req1_ready, rsp1_valid, rsp1_word
   );
endinterface
`default_nettype wire

// File: rtl/sbox_word_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sbox_word_arbiter                                                     |
// | Round-robin word arbiter feeding one pipelined 8-bit S-box serially.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sbox_word_arbiter #(
   parameter int SBOX_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sbox_word_arbiter_if.slave   bus,
   output logic [7:0]           sbox_in,
   input  logic [7:0]           sbox_out,
   output logic                 busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]          r_state;
   logic [1:0]          w_next;
   logic [31:0]         r_word;
   logic [31:0]         r_result;
   logic                r_owner;
   logic                r_last;       // last granted requester; tie goes to the other
   logic [1:0]          r_issue_idx;
   logic [1:0]          r_cap_idx;
   logic [SBOX_LAT-1:0] r_tag;
   logic                w_gnt0;
   logic                w_gnt1;
   logic                w_req_hs;
   logic                w_rsp_hs;
   logic                w_issue;
   logic                w_capture;

   always_comb begin
      w_gnt0 = bus.req0_valid && (!bus.req1_valid ||  r_last);
      w_gnt1 = bus.req1_valid && (!bus.req0_valid || !r_last);
   end

   assign w_req_hs  = (r_state == S_IDLE) && (w_gnt0 || w_gnt1);
   assign w_issue   = (r_state == S_ISSUE);
   assign w_capture = r_tag[SBOX_LAT-1];
   assign w_rsp_hs  = (r_state == S_RESP) && (r_owner ? bus.rsp1_ready : bus.rsp0_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_req_hs) w_next = S_ISSUE;
         S_ISSUE: if (r_issue_idx == 2'd3) w_next = S_DRAIN;
         S_DRAIN: if (w_capture && (r_cap_idx == 2'd3)) w_next = S_RESP;
         S_RESP:  if (w_rsp_hs) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.rsp0_valid = 1'b0;
      bus.rsp1_valid = 1'b0;
      bus.rsp0_word  = 32'h0;
      bus.rsp1_word  = 32'h0;
      sbox_in        = 8'h00;
      busy           = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            bus.req0_ready = w_gnt0;
            bus.req1_ready = w_gnt1;
         end
         S_ISSUE: sbox_in = r_word[{r_issue_idx, 3'b000} +: 8];
         S_RESP: begin
            if (r_owner) begin
               bus.rsp1_valid = 1'b1;
               bus.rsp1_word  = r_result;
            end else begin
               bus.rsp0_valid = 1'b1;
               bus.rsp0_word  = r_result;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word      <= 32'h0;
         r_result    <= 32'h0;
         r_owner     <= 1'b0;
         r_last      <= 1'b1;
         r_issue_idx <= 2'd0;
         r_cap_idx   <= 2'd0;
      end else begin
         if (w_req_hs) begin
            r_word  <= w_gnt1 ? bus.req1_word : bus.req0_word;
            r_owner <= w_gnt1;
            r_last  <= w_gnt1;
         end
         if (w_issue) begin
            r_issue_idx <= r_issue_idx + 2'd1;
         end
         if (w_capture) begin
            r_result[{r_cap_idx, 3'b000} +: 8] <= sbox_out;
            r_cap_idx                          <= r_cap_idx + 2'd1;
         end
      end
   end

   // Tag marks which sbox_out cycles carry a byte of the current word.
   generate
      if (SBOX_LAT == 1) begin : g_tag_single
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_tag <= '0;
            end else begin
               r_tag <= w_issue;
            end
         end
      end else begin : g_tag_shift
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_tag <= '0;
            end else begin
               r_tag <= {r_tag[SBOX_LAT-2:0], w_issue};
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sbox_word_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sbox_word_arbiter                                                  |
// | Directed bench with an AES S-box pipe and a timeline reference model. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_sbox_word_arbiter;
   localparam int SBOX_LAT = 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] sbox_in;
   logic [7:0] sbox_out;
   logic       busy;

   sbox_word_arbiter_if bus();

   sbox_word_arbiter #(.SBOX_LAT(SBOX_LAT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .sbox_in  (sbox_in),
      .sbox_out (sbox_out),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   logic [7:0] sbox_tab [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   // External S-box: SBOX_LAT register stages from sbox_in to sbox_out.
   logic [7:0] pipe [SBOX_LAT] = '{default: 8'h00};
   always @(posedge clk) begin
      pipe[0] <= sbox_tab[sbox_in];
      for (int i = 1; i < SBOX_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign sbox_out = pipe[SBOX_LAT-1];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] subword(input logic [31:0] w);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox_tab[w[8*k +: 8]];
      return r;
   endfunction

   // Reference model: word in service plus elapsed cycles since its handshake.
   logic        m_busy  = 1'b0;
   logic        m_owner = 1'b0;
   logic        m_last  = 1'b1;
   logic [31:0] m_word  = 32'h0;
   int          m_t     = 0;
   logic        e_r0, e_r1, e_v0, e_v1;
   logic [31:0] e_w0, e_w1;
   logic [7:0]  e_sb;

   always @(negedge clk) begin
      e_r0 = 1'b0; e_r1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0;
      e_w0 = 32'h0; e_w1 = 32'h0; e_sb = 8'h00;
      if (!rst_n) begin
         m_busy = 1'b0; m_last = 1'b1; m_t = 0;
      end else if (!m_busy) begin
         if (bus.req0_valid && bus.req1_valid) begin
            if (m_last) e_r0 = 1'b1; else e_r1 = 1'b1;
         end else begin
            e_r0 = bus.req0_valid;
            e_r1 = bus.req1_valid;
         end
      end else begin
         if (m_t >= 1 && m_t <= 4) e_sb = m_word[8*(m_t-1) +: 8];
         if (m_t >= 5 + SBOX_LAT) begin
            if (m_owner) begin e_v1 = 1'b1; e_w1 = subword(m_word); end
            else         begin e_v0 = 1'b1; e_w0 = subword(m_word); end
         end
      end
      chk("m_busy",      busy,           rst_n && m_busy);
      chk("m_req0_rdy",  bus.req0_ready, e_r0);
      chk("m_req1_rdy",  bus.req1_ready, e_r1);
      chk("m_one_ready", bus.req0_ready && bus.req1_ready, 1'b0);
      chk("m_sbox_in",   sbox_in,        e_sb);
      chk("m_rsp0_vld",  bus.rsp0_valid, e_v0);
      chk("m_rsp1_vld",  bus.rsp1_valid, e_v1);
      chk("m_rsp0_word", bus.rsp0_word,  e_w0);
      chk("m_rsp1_word", bus.rsp1_word,  e_w1);
      if (rst_n) begin
         if (!m_busy) begin
            if (e_r0 || e_r1) begin
               m_busy = 1'b1; m_t = 1; m_owner = e_r1; m_last = e_r1;
               m_word = e_r1 ? bus.req1_word : bus.req0_word;
            end
         end else if (m_t >= 5 + SBOX_LAT &&
                      (m_owner ? bus.rsp1_ready : bus.rsp0_ready)) begin
            m_busy = 1'b0;
         end else begin
            m_t++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_mid();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   logic [31:0] got0 [$];
   logic [31:0] got1 [$];
   logic [7:0]  gbits;
   int          ngr;

   // Both requesters hold valid/word until accepted, then present their next word.
   task automatic run_stream(input int budget);
      int  cyc = 0;
      logic hs0, hs1;
      got0.delete(); got1.delete(); gbits = 8'h00; ngr = 0;
      tick();
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      if (q0.size() > 0) begin bus.req0_valid = 1'b1; bus.req0_word = q0[0]; end
      if (q1.size() > 0) begin bus.req1_valid = 1'b1; bus.req1_word = q1[0]; end
      while ((q0.size() > 0 || q1.size() > 0 || busy) && cyc < budget) begin
         at_mid();
         hs0 = bus.req0_valid && bus.req0_ready;
         hs1 = bus.req1_valid && bus.req1_ready;
         if (bus.rsp0_valid) got0.push_back(bus.rsp0_word);
         if (bus.rsp1_valid) got1.push_back(bus.rsp1_word);
         if (hs0 || hs1) begin
            gbits[ngr] = hs1;
            ngr++;
         end
         tick();
         if (hs0) begin
            void'(q0.pop_front());
            if (q0.size() > 0) bus.req0_word = q0[0]; else bus.req0_valid = 1'b0;
         end
         if (hs1) begin
            void'(q1.pop_front());
            if (q1.size() > 0) bus.req1_word = q1[0]; else bus.req1_valid = 1'b0;
         end
         cyc++;
      end
      chk("stream_budget", cyc < budget, 1'b1);
   endtask

   logic [7:0] seq1 [4] = '{8'h03, 8'h02, 8'h01, 8'h00};
   logic       seen0;
   logic [31:0] w7;

   initial begin
      bus.req0_valid = 1'b0; bus.req0_word = 32'h0; bus.rsp0_ready = 1'b0;
      bus.req1_valid = 1'b0; bus.req1_word = 32'h0; bus.rsp1_ready = 1'b0;
      tick();
      tick();
      at_mid();
      chk("reset_busy", busy, 1'b0);
      chk("reset_rsp0_word", bus.rsp0_word, 32'h0);
      chk("reset_sbox_in", sbox_in, 8'h00);
      rst_n = 1'b1;

      // Single word on requester 0 with exact latency.
      tick();
      bus.req0_valid = 1'b1; bus.req0_word = 32'h00010203; bus.rsp0_ready = 1'b1;
      at_mid();
      chk("t1_ready", bus.req0_ready, 1'b1);
      tick();
      bus.req0_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         at_mid();
         chk("t1_sbox_in", sbox_in, seq1[k]);
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         at_mid();
         chk("t1_early_vld", bus.rsp0_valid, 1'b0);
         tick();
      end
      at_mid();
      chk("t1_vld", bus.rsp0_valid, 1'b1);
      chk("t1_word", bus.rsp0_word, 32'h637c777b);
      tick();
      bus.rsp0_ready = 1'b0;
      at_mid();
      chk("t1_idle", busy, 1'b0);

      // Requester 1 with a stalled consumer.
      tick();
      bus.req1_valid = 1'b1; bus.req1_word = 32'h53ff1020; bus.rsp1_ready = 1'b0;
      at_mid();
      chk("t2_ready", bus.req1_ready, 1'b1);
      tick();
      bus.req1_valid = 1'b0;
      for (int i = 0; i < 20 && !bus.rsp1_valid; i++) begin
         at_mid();
         if (!bus.rsp1_valid) tick();
      end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin tick(); at_mid(); end
         chk("t2_vld", bus.rsp1_valid, 1'b1);
         chk("t2_word", bus.rsp1_word, 32'hed16cab7);
         chk("t2_busy", busy, 1'b1);
         chk("t2_rsp0", bus.rsp0_valid, 1'b0);
      end
      tick();
      bus.rsp1_ready = 1'b1;
      at_mid();
      chk("t2_vld_hs", bus.rsp1_valid, 1'b1);
      tick();
      bus.rsp1_ready = 1'b0;
      at_mid();
      chk("t2_done", busy, 1'b0);

      // Tie after reset: requester 0 first.
      do_reset();
      q0 = '{32'h00000000};
      q1 = '{32'h01010101};
      run_stream(60);
      chk("t3_ngr", ngr, 2);
      chk("t3_order", gbits[1:0], 2'b10);
      chk("t3_n0", got0.size(), 1);
      chk("t3_n1", got1.size(), 1);
      if (got0.size() == 1) chk("t3_r0", got0[0], 32'h63636363);
      if (got1.size() == 1) chk("t3_r1", got1[0], 32'h7c7c7c7c);

      // Continuous streams: 4 words vs 2 words.
      q0 = '{32'h00010203, 32'h53ff1020, 32'hffffffff, 32'h00000000};
      q1 = '{32'h01010101, 32'h00000000};
      run_stream(200);
      chk("t4_ngr", ngr, 6);
      chk("t4_order", gbits[5:0], 6'b001010);
      chk("t4_n0", got0.size(), 4);
      chk("t4_n1", got1.size(), 2);
      if (got0.size() == 4) begin
         chk("t4_r0a", got0[0], 32'h637c777b);
         chk("t4_r0b", got0[1], 32'hed16cab7);
         chk("t4_r0c", got0[2], 32'h16161616);
         chk("t4_r0d", got0[3], subword(32'h00000000));
      end
      if (got1.size() == 2) begin
         chk("t4_r1a", got1[0], 32'h7c7c7c7c);
         chk("t4_r1b", got1[1], 32'h63636363);
      end
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;

      // Reset during ISSUE, then a fresh word on requester 1.
      tick();
      bus.req0_valid = 1'b1; bus.req0_word = 32'h00010203;
      at_mid();
      chk("t5_ready", bus.req0_ready, 1'b1);
      tick();
      bus.req0_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      at_mid();
      chk("t5_rst_busy", busy, 1'b0);
      chk("t5_rst_sbox", sbox_in, 8'h00);
      tick();
      rst_n = 1'b1;
      tick();
      bus.req1_valid = 1'b1; bus.req1_word = 32'hffffffff;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      at_mid();
      chk("t5_ready1", bus.req1_ready, 1'b1);
      tick();
      bus.req1_valid = 1'b0;
      for (int k = 1; k < 7; k++) begin
         at_mid();
         chk("t5_no_rsp0", bus.rsp0_valid, 1'b0);
         chk("t5_no_rsp1", bus.rsp1_valid, 1'b0);
         tick();
      end
      at_mid();
      chk("t5_vld", bus.rsp1_valid, 1'b1);
      chk("t5_word", bus.rsp1_word, 32'h16161616);
      tick();
      bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

      // rsp0_ready pulsed during ISSUE is ignored.
      tick();
      bus.req0_valid = 1'b1; bus.req0_word = 32'h00010203;
      at_mid();
      tick();
      bus.req0_valid = 1'b0;
      tick();
      bus.rsp0_ready = 1'b1;
      tick();
      bus.rsp0_ready = 1'b0;
      tick(); tick(); tick(); tick();
      at_mid();
      chk("t6_vld", bus.rsp0_valid, 1'b1);
      tick();
      at_mid();
      chk("t6_hold_vld", bus.rsp0_valid, 1'b1);
      chk("t6_hold_word", bus.rsp0_word, 32'h637c777b);
      tick();
      bus.rsp0_ready = 1'b1;
      at_mid();
      tick();
      bus.rsp0_ready = 1'b0;
      at_mid();
      chk("t6_done", busy, 1'b0);

      // Requester 0 withdraws while requester 1 holds the grant.
      tick();
      bus.req0_valid = 1'b1; bus.req0_word = 32'h11111111;
      bus.req1_valid = 1'b1; bus.req1_word = 32'h20202020;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      at_mid();
      chk("t7_ready1", bus.req1_ready, 1'b1);
      chk("t7_ready0", bus.req0_ready, 1'b0);
      tick();
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      seen0 = 1'b0;
      w7 = 32'h0;
      for (int i = 0; i < 20; i++) begin
         at_mid();
         if (bus.rsp0_valid) seen0 = 1'b1;
         if (bus.rsp1_valid) w7 = bus.rsp1_word;
         tick();
      end
      chk("t7_r1", w7, 32'hb7b7b7b7);
      chk("t7_no_r0", seen0, 1'b0);
      at_mid();
      chk("t7_idle", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
